// File: rtl/cu_mc.sv
// Multi-cycle control unit for the mycpu datapath: fetch with memory wait states,
// single execute state, counted repeat-shift and halt/resume.
module cu_mc #(
  parameter int unsigned IW   = 16,
  parameter int unsigned RA_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IW-1:0]       ins_in,
  input  logic                z_in,
  input  logic                n_in,
  input  logic                mem_rdy_in,
  input  logic                go_in,
  output logic                il_out,
  output logic [1:0]          ps_out,
  output logic                rw_out,
  output logic [3*RA_W-1:0]   rs_out,
  output logic                mm_out,
  output logic [1:0]          md_out,
  output logic                mb_out,
  output logic [3:0]          fs_out,
  output logic                wen_out,
  output logic                iom_out,
  output logic                halted_out,
  output logic                illegal_out
);

  localparam int unsigned OP_W = IW - 3*RA_W;

  if (IW < 3*RA_W + 5) begin : g_bad_op_w
    $error("cu_mc: opcode field IW-3*RA_W must be at least 5 bits");
  end

  localparam logic [OP_W-1:0] OP_LDI  = OP_W'(5'h10);
  localparam logic [OP_W-1:0] OP_ADI  = OP_W'(5'h11);
  localparam logic [OP_W-1:0] OP_LD   = OP_W'(5'h12);
  localparam logic [OP_W-1:0] OP_ST   = OP_W'(5'h13);
  localparam logic [OP_W-1:0] OP_BRZ  = OP_W'(5'h14);
  localparam logic [OP_W-1:0] OP_BRN  = OP_W'(5'h15);
  localparam logic [OP_W-1:0] OP_JMP  = OP_W'(5'h16);
  localparam logic [OP_W-1:0] OP_IOR  = OP_W'(5'h17);
  localparam logic [OP_W-1:0] OP_IOW  = OP_W'(5'h18);
  localparam logic [OP_W-1:0] OP_SHLN = OP_W'(5'h19);
  localparam logic [OP_W-1:0] OP_HAL  = OP_W'(5'h1A);
  localparam logic [OP_W-1:0] OP_NALU = OP_W'(5'h10);

  typedef enum logic [2:0] {
    S_RST = 3'd0,
    S_INF = 3'd1,
    S_EX0 = 3'd2,
    S_RPT = 3'd3,
    S_HLT = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [RA_W-1:0]   cnt_q, cnt_d;
  logic              first_q, first_d;

  logic [OP_W-1:0]   opcode;
  logic [RA_W-1:0]   dr, sa, sb;

  assign opcode = ins_in[IW-1:3*RA_W];
  assign dr     = ins_in[3*RA_W-1:2*RA_W];
  assign sa     = ins_in[2*RA_W-1:RA_W];
  assign sb     = ins_in[RA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  // Next-state and control decode; rst masks everything to defaults.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    first_d     = first_q;
    il_out      = 1'b0;
    ps_out      = 2'b00;
    rw_out      = 1'b0;
    rs_out      = '0;
    mm_out      = 1'b0;
    md_out      = 2'b00;
    mb_out      = 1'b0;
    fs_out      = 4'b0000;
    wen_out     = 1'b1;
    iom_out     = 1'b0;
    halted_out  = 1'b0;
    illegal_out = 1'b0;
    if (!rst) begin
      case (state_q)
        S_RST: state_d = S_INF;
        S_INF: begin
          mm_out = 1'b1;
          il_out = mem_rdy_in;
          if (mem_rdy_in) state_d = S_EX0;
        end
        S_EX0: begin
          rs_out  = {dr, sa, sb};
          ps_out  = 2'b01;
          state_d = S_INF;
          if (opcode < OP_NALU) begin
            rw_out = 1'b1;
            fs_out = opcode[3:0];
          end else begin
            case (opcode)
              OP_LDI: begin rw_out = 1'b1; mb_out = 1'b1; fs_out = 4'b1100; end
              OP_ADI: begin rw_out = 1'b1; mb_out = 1'b1; fs_out = 4'b0010; end
              OP_LD: begin
                md_out = 2'b01;
                rw_out = mem_rdy_in;
                if (!mem_rdy_in) begin ps_out = 2'b00; state_d = S_EX0; end
              end
              OP_ST: begin
                wen_out = 1'b0;
                if (!mem_rdy_in) begin ps_out = 2'b00; state_d = S_EX0; end
              end
              OP_BRZ: ps_out = z_in ? 2'b10 : 2'b01;
              OP_BRN: ps_out = n_in ? 2'b10 : 2'b01;
              OP_JMP: ps_out = 2'b11;
              OP_IOR: begin rw_out = 1'b1; md_out = 2'b10; iom_out = 1'b1; end
              OP_IOW: begin wen_out = 1'b0; iom_out = 1'b1; end
              OP_SHLN: begin
                cnt_d   = sb;
                first_d = 1'b1;
                if (sb != '0) begin ps_out = 2'b00; state_d = S_RPT; end
              end
              OP_HAL: begin ps_out = 2'b00; state_d = S_HLT; end
              default: illegal_out = 1'b1;
            endcase
          end
        end
        // First pass shifts sa into dr, later passes shift dr in place.
        S_RPT: begin
          rw_out  = 1'b1;
          fs_out  = 4'b1110;
          rs_out  = {dr, first_q ? sa : dr, sb};
          cnt_d   = cnt_q - RA_W'(1);
          first_d = 1'b0;
          if (cnt_q == RA_W'(1)) begin
            ps_out  = 2'b01;
            state_d = S_INF;
          end
        end
        S_HLT: begin
          halted_out = 1'b1;
          if (go_in) begin
            ps_out  = 2'b01;
            state_d = S_INF;
          end
        end
        default: state_d = S_RST;
      endcase
    end
  end

endmodule

// File: doc/cu_mc.md
Name: cu_mc

Overview:
- Parametrised multi-cycle control unit for the mycpu datapath; next generation of the single-cycle-execute control unit.
- Decodes the instruction register and drives PC, register-file, function-unit, memory and I/O controls.
- New over the previous generation: generalised instruction and register-address widths, memory-ready wait states on fetch, LD and ST, a counted repeat-shift instruction, halt with external resume, and illegal-opcode flagging.

Parameters:
- IW, 16: instruction width.
- RA_W, 3: register address field width. Opcode width is OP_W = IW-3*RA_W, which must be at least 5; an elaboration error is raised otherwise.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- ins_in  in  IW  instruction. Fields: opcode=[IW-1:3*RA_W], dr=[3*RA_W-1:2*RA_W], sa=[2*RA_W-1:RA_W], sb=[RA_W-1:0].
- z_in  in  1  zero flag.
- n_in  in  1  negative flag.
- mem_rdy_in  in  1  memory access completes this cycle.
- go_in  in  1  resume from halt.
- il_out  out  1  instruction-register load.
- ps_out  out  2  PC control: 00 hold, 01 increment, 10 branch, 11 jump.
- rw_out  out  1  register-file write.
- rs_out  out  3*RA_W  {dr,sa,sb} select.
- mm_out  out  1  memory address mux: 1=PC, 0=register A.
- md_out  out  2  write-back mux: 00 function unit, 01 memory, 10 I/O.
- mb_out  out  1  B mux: 1=immediate.
- fs_out  out  4  function select.
- wen_out  out  1  memory/I/O write enable, active-low.
- iom_out  out  1  I/O space select.
- halted_out  out  1  1 while in HLT.
- illegal_out  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Outputs are combinational from state, ins_in and the inputs.
- While rst=1, all outputs are forced to their default values and the state register loads RST at the clock edge. Reset mid-operation (including RPT or HLT) aborts immediately.
- Default output values: ps=00, il=0, rw=0, rs=0, mm=0, md=00, mb=0, fs=0000, wen=1, iom=0, halted=0, illegal=0.
- States: RST, INF, EX0, RPT, HLT. Counter cnt_r is RA_W bits; flag first_r is 1 bit.
- RST: default outputs; next state INF.
- INF: mm=1, il=mem_rdy_in. If mem_rdy_in=1 go to EX0, else stay in INF.
- EX0: rs={dr,sa,sb}. Unless stated otherwise, ps=01 and next state is INF.
- Opcodes 0x00-0x0F (register ALU ops): rw=1, fs=opcode[3:0].
- 0x10 LDI: rw=1, mb=1, fs=1100.
- 0x11 ADI: rw=1, mb=1, fs=0010.
- 0x12 LD: md=01, rw=mem_rdy_in. If mem_rdy_in=0: ps=00, stay in EX0.
- 0x13 ST: wen=0 for every cycle in EX0. If mem_rdy_in=0: ps=00, stay in EX0.
- 0x14 BRZ: ps = z_in ? 10 : 01.
- 0x15 BRN: ps = n_in ? 10 : 01.
- 0x16 JMP: ps=11.
- 0x17 IOR: rw=1, md=10, iom=1.
- 0x18 IOW: wen=0, iom=1.
- 0x19 SHLN: cnt_r<=sb and first_r<=1. If sb==0, behaves as a NOP (ps=01, next INF). Otherwise ps=00 and next state RPT.
- 0x1A HAL: ps=00; next state HLT.
- Any other opcode: illegal=1 for that EX0 cycle, ps=01, no write; next INF.
- RPT: rw=1, fs=1110, rs={dr, first_r?sa:dr, sb}. Each cycle cnt_r decrements and first_r<=0.
  - When cnt_r==1: ps=01, next INF.
  - Otherwise ps=00, stay in RPT.
  - Result: dr = sa<<N in exactly N RPT cycles.
- HLT: halted=1, ps=00. If go_in=1: ps=01, next INF. The go_in cycle still shows halted=1.
- Flags z_in/n_in are sampled only in EX0 for BRZ/BRN.
- mem_rdy_in is ignored outside INF and LD/ST in EX0. A wait of unbounded length is legal.

Test Plan:
- Reset then mem_rdy_in=1 held, ins_in=0x0000 -> RST one cycle, INF with il=1 and mm=1, EX0 with ps=01, rw=1, fs=0000.
- INF with mem_rdy_in low for 3 cycles -> il=0, ps=00 for 3 cycles; il=1 on the 4th cycle; then EX0.
- LD (opcode 0x12, dr=2, sa=5) with mem_rdy_in low for 2 EX0 cycles -> rw=0, ps=00, md=01 twice; then rw=1, ps=01, rs=0o250 (dr=2, sa=5, sb=0); next INF.
- SHLN dr=1, sa=4, sb=3 -> exactly 3 RPT cycles with rw=1, fs=1110; rs A field is 4, then 1, then 1; ps=01 only on the last cycle. With sb=0 -> no RPT state, ps=01 in EX0.
- HAL, go_in low for 5 cycles then high -> halted=1 and ps=00 for 5 cycles, ps=01 on the go cycle, then INF. BRZ with z_in=1 -> ps=10; with z_in=0 -> ps=01.
- Opcode 0x7F -> illegal pulse for 1 cycle, rw=0, ps=01. rst=1 in the 2nd RPT cycle -> outputs take default values that cycle; RST state then INF.
